gbpt_ghr_hash_unit: RTL and testbench
=====================================

Name: gbpt_ghr_hash_unit

Overview:
Owns the speculative global history register (GHR) and produces registered GBPT indices from fetch PC, folded GH and ASID. It is the parametrised successor to the combinational GBPT hash. GH length is decoupled from index width by XOR folding. It adds a valid/ready output stage, speculative history update, and mispredict restore. It sits between the fetch PC generator and the GBPT read port.

Parameters:
INDEX_WIDTH, GBPT_INDEX_WIDTH+LOG_GBPT_ENTRIES_PER_BLOCK, full index width, within-block bits included
GH_LEN, GH_LENGTH, GHR length in bits, any value >= 1, may exceed INDEX_WIDTH
ASID_W, ASID_WIDTH, ASID width
PC_LSB, 1, lowest PC bit used in hash

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
req_valid  in  1  hash request
req_ready  out  1  request accepted when req_valid & req_ready
req_PC  in  32  fetch PC
req_ASID  in  ASID_W  address space ID
idx_valid  out  1  index output valid
idx_ready  in  1  consumer accepts index
idx  out  INDEX_WIDTH  hashed GBPT index
idx_GH  out  GH_LEN  GHR snapshot used for idx, for later restore
upd_valid  in  1  speculative history update
upd_taken  in  1  predicted direction shifted in
restore_valid  in  1  mispredict restore
restore_GH  in  GH_LEN  corrected history, already containing resolved outcome
GH_out  out  GH_LEN  current GHR value

Behaviour:
- Reset (nRST low, async): GHR=0, idx_valid=0, idx=0, idx_GH=0. req_ready=1 after reset because it is combinational from idx_valid.
- GHR next-state, priority order:
  - restore_valid: GHR<=restore_GH.
  - else upd_valid: GHR<={GHR[GH_LEN-2:0],upd_taken}. When GH_LEN=1, GHR<=upd_taken.
  - else hold.
  - restore wins over a same-cycle update; that update is dropped.
- fold(GH): split GH into ceil(GH_LEN/INDEX_WIDTH) chunks of INDEX_WIDTH bits, LSB chunk first. Zero-pad the top chunk, then XOR all chunks.
- ASID term: zero-extend to INDEX_WIDTH, or XOR-fold the same way if ASID_W>INDEX_WIDTH.
- hash = req_PC[INDEX_WIDTH+PC_LSB-1:PC_LSB] ^ fold(GHR) ^ ASID term.
  - Uses the registered GHR, i.e. the pre-update value of the current cycle.
  - The PC slice bits above 31 read as 0.
- Output stage (1 entry):
  - req_ready = !idx_valid | idx_ready.
  - On accept: next cycle idx_valid=1, idx=hash, idx_GH=GHR as sampled.
  - If idx_valid & idx_ready & !accept: idx_valid<=0.
  - Latency: request to idx is exactly 1 cycle.
  - Full throughput, one index per cycle, when idx_ready is held 1.
- Stall: idx_valid & !idx_ready holds idx and idx_GH stable. req_ready=0 and the request is not accepted. The requester must hold req_valid/req_PC.
- GHR updates and restores proceed during stall. They never modify a held idx/idx_GH.
- Same cycle accept + update: idx reflects old GHR; GH_out shows new GHR next cycle.
- Reset mid-stall: output dropped, idx_valid=0 immediately.

Optional Feature:
Macro GBPT_HASH_ASID_EN.
- Defined: ASID term XORed into hash as above.
- Undefined: ASID term is 0 and req_ASID is ignored. The port still exists.

Test Plan:
Tests use INDEX_WIDTH=8, GH_LEN=12, ASID_W=4, PC_LSB=1, with GBPT_HASH_ASID_EN defined unless noted.
1. Reset, GHR=0; req PC=0x00000100, ASID=0, idx_ready=1 -> next cycle idx_valid=1, idx=0x80, idx_GH=0x000.
2. upd_taken 1,1,1,0 on 4 consecutive cycles -> GH_out=0x00E; then req PC=0x100, ASID=0x3 -> idx=0x80^0x0E^0x03=0x8D, idx_GH=0x00E.
3. GHR=0xFFF via restore; req PC=0, ASID=0 -> fold=0xFF^0x0F, idx=0xF0.
4. Accept req, then idx_ready=0 for 3 cycles with new req_valid=1 and upd_valid toggling -> idx/idx_GH unchanged, req_ready=0 throughout. idx_ready=1 -> held request accepted, idx_valid stays 1 next cycle with new idx.
5. GHR=0x123; same cycle restore_valid=1 restore_GH=0x0AA plus upd_valid=1 upd_taken=1 -> GH_out=0x0AA. Req PC=0, ASID=0 -> idx=0xAA.
6. GBPT_HASH_ASID_EN undefined; GHR=0, PC=0x100, ASID=0xF -> idx=0x80, identical to ASID=0.

Source files
------------

// File: rtl/gbpt_ghr_hash_unit.sv
// Speculative GHR owner and registered GBPT index hash (PC ^ folded GHR ^ ASID).
// Optional ASID term enabled by defining GBPT_HASH_ASID_EN; otherwise req_ASID is ignored.
module gbpt_ghr_hash_unit #(
   parameter int INDEX_WIDTH = 8,
   parameter int GH_LEN      = 12,
   parameter int ASID_W      = 4,
   parameter int PC_LSB      = 1
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [31:0]            req_PC,
   input  logic [ASID_W-1:0]      req_ASID,
   output logic                   idx_valid,
   input  logic                   idx_ready,
   output logic [INDEX_WIDTH-1:0] idx,
   output logic [GH_LEN-1:0]      idx_GH,
   input  logic                   upd_valid,
   input  logic                   upd_taken,
   input  logic                   restore_valid,
   input  logic [GH_LEN-1:0]      restore_GH,
   output logic [GH_LEN-1:0]      GH_out
);

   localparam int GH_CHUNKS  = (GH_LEN + INDEX_WIDTH - 1) / INDEX_WIDTH;
   localparam int GH_PAD_W   = GH_CHUNKS * INDEX_WIDTH;

   logic [GH_LEN-1:0]      r_ghr;
   logic [GH_LEN-1:0]      w_ghr_shift;
   logic [GH_LEN-1:0]      w_ghr_nxt;
   logic [GH_PAD_W-1:0]    w_gh_pad;
   logic [INDEX_WIDTH-1:0] w_gh_fold;
   logic [31:0]            w_pc_shr;
   logic [INDEX_WIDTH-1:0] w_pc_term;
   logic [INDEX_WIDTH-1:0] w_asid_term;
   logic [INDEX_WIDTH-1:0] w_hash;
   logic                   w_accept;

   logic                   r_idx_valid;
   logic [INDEX_WIDTH-1:0] r_idx;
   logic [GH_LEN-1:0]      r_idx_gh;

   // ---------------- history register ----------------
   generate
      if (GH_LEN == 1) begin : g_gh_one
         assign w_ghr_shift = upd_taken;
      end else begin : g_gh_multi
         assign w_ghr_shift = {r_ghr[GH_LEN-2:0], upd_taken};
      end
   endgenerate

   // Restore outranks a same-cycle speculative update; that update is lost.
   always_comb begin
      w_ghr_nxt = r_ghr;
      if (restore_valid) begin
         w_ghr_nxt = restore_GH;
      end else if (upd_valid) begin
         w_ghr_nxt = w_ghr_shift;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_ghr <= '0;
      end else begin
         r_ghr <= w_ghr_nxt;
      end
   end

   // ---------------- hash ----------------
   assign w_gh_pad = GH_PAD_W'(r_ghr);

   always_comb begin
      w_gh_fold = '0;
      for (int i = 0; i < GH_CHUNKS; i++) begin
         w_gh_fold = w_gh_fold ^ w_gh_pad[i*INDEX_WIDTH +: INDEX_WIDTH];
      end
   end

   // PC bits above bit 31 shift in as zero.
   assign w_pc_shr  = req_PC >> PC_LSB;
   assign w_pc_term = INDEX_WIDTH'(w_pc_shr);

`ifdef GBPT_HASH_ASID_EN
   localparam int ASID_CHUNKS = (ASID_W + INDEX_WIDTH - 1) / INDEX_WIDTH;
   localparam int ASID_PAD_W  = ASID_CHUNKS * INDEX_WIDTH;

   logic [ASID_PAD_W-1:0] w_asid_pad;
   assign w_asid_pad = ASID_PAD_W'(req_ASID);

   always_comb begin
      w_asid_term = '0;
      for (int i = 0; i < ASID_CHUNKS; i++) begin
         w_asid_term = w_asid_term ^ w_asid_pad[i*INDEX_WIDTH +: INDEX_WIDTH];
      end
   end
`else
   logic w_asid_unused;
   assign w_asid_unused = ^req_ASID;
   assign w_asid_term   = '0;
`endif

   assign w_hash = w_pc_term ^ w_gh_fold ^ w_asid_term;

   // ---------------- single-entry output stage ----------------
   assign req_ready = !r_idx_valid || idx_ready;
   assign w_accept  = req_valid && req_ready;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_idx_valid <= 1'b0;
         r_idx       <= '0;
         r_idx_gh    <= '0;
      end else if (w_accept) begin
         r_idx_valid <= 1'b1;
         r_idx       <= w_hash;
         r_idx_gh    <= r_ghr;
      end else if (idx_ready) begin
         r_idx_valid <= 1'b0;
      end
   end

   assign idx_valid = r_idx_valid;
   assign idx       = r_idx;
   assign idx_GH    = r_idx_gh;
   assign GH_out    = r_ghr;

endmodule

// File: tb/tb_gbpt_ghr_hash_unit.sv
// Self-checking bench for gbpt_ghr_hash_unit: directed scenarios plus random traffic
// compared against an arithmetic reference model.
module tb_gbpt_ghr_hash_unit;

   localparam int IW     = 8;
   localparam int GHL    = 12;
   localparam int AW     = 4;
   localparam int PCL    = 1;

   logic            CLK = 1'b0;
   logic            nRST;
   logic            req_valid;
   logic            req_ready;
   logic [31:0]     req_PC;
   logic [AW-1:0]   req_ASID;
   logic            idx_valid;
   logic            idx_ready;
   logic [IW-1:0]   idx;
   logic [GHL-1:0]  idx_GH;
   logic            upd_valid;
   logic            upd_taken;
   logic            restore_valid;
   logic [GHL-1:0]  restore_GH;
   logic [GHL-1:0]  GH_out;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int unsigned m_ghr;
   bit          m_vld;
   int unsigned m_idx;
   int unsigned m_idx_gh;

   gbpt_ghr_hash_unit #(
      .INDEX_WIDTH (IW),
      .GH_LEN      (GHL),
      .ASID_W      (AW),
      .PC_LSB      (PCL)
   ) u_dut (
      .CLK           (CLK),
      .nRST          (nRST),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_PC        (req_PC),
      .req_ASID      (req_ASID),
      .idx_valid     (idx_valid),
      .idx_ready     (idx_ready),
      .idx           (idx),
      .idx_GH        (idx_GH),
      .upd_valid     (upd_valid),
      .upd_taken     (upd_taken),
      .restore_valid (restore_valid),
      .restore_GH    (restore_GH),
      .GH_out        (GH_out)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned fold(input int unsigned v);
      int unsigned r = 0;
      while (v != 0) begin
         r = r ^ (v % (1 << IW));
         v = v / (1 << IW);
      end
      return r;
   endfunction

   function automatic int unsigned model_hash(input int unsigned pc, input int unsigned asid,
                                              input int unsigned gh);
      int unsigned a;
      a = 0;
`ifdef GBPT_HASH_ASID_EN
      a = fold(asid);
`endif
      return ((pc >> PCL) % (1 << IW)) ^ fold(gh) ^ a;
   endfunction

   function automatic void model_reset();
      m_ghr = 0; m_vld = 0; m_idx = 0; m_idx_gh = 0;
   endfunction

   // One cycle: drive at negedge, check settled outputs, advance model, wait for next negedge.
   task automatic step(input bit rv, input int unsigned pc, input int unsigned asid, input bit ir,
                       input bit uv, input bit ut, input bit rs, input int unsigned rgh);
      bit rr;
      req_valid = rv; req_PC = pc; req_ASID = AW'(asid); idx_ready = ir;
      upd_valid = uv; upd_taken = ut; restore_valid = rs; restore_GH = GHL'(rgh);
      #1;
      rr = !m_vld || ir;
      check("req_ready", req_ready, rr);
      check("idx_valid", idx_valid, m_vld);
      check("idx",       idx,       m_idx);
      check("idx_GH",    idx_GH,    m_idx_gh);
      check("GH_out",    GH_out,    m_ghr);
      if (rv && rr) begin
         m_vld    = 1;
         m_idx    = model_hash(pc, asid, m_ghr);
         m_idx_gh = m_ghr;
      end else if (m_vld && ir) begin
         m_vld = 0;
      end
      if (rs)      m_ghr = rgh % (1 << GHL);
      else if (uv) m_ghr = (m_ghr * 2 + ut) % (1 << GHL);
      @(negedge CLK);
   endtask

   task automatic idle();
      step(0, 0, 0, 1, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      nRST = 0;
      req_valid = 0; req_PC = 0; req_ASID = 0; idx_ready = 1;
      upd_valid = 0; upd_taken = 0; restore_valid = 0; restore_GH = 0;
      model_reset();
      repeat (2) @(negedge CLK);
      nRST = 1;
   endtask

   initial begin
      int unsigned held_idx, held_gh, exp_asid_f;
      bit p_rv; int unsigned p_pc, p_asid;

      do_reset();
      // 1: reset values and basic request
      #1;
      check("rst_idx_valid", idx_valid, 0);
      check("rst_idx",       idx,       0);
      check("rst_idx_GH",    idx_GH,    0);
      check("rst_GH_out",    GH_out,    0);
      check("rst_req_ready", req_ready, 1);
      @(negedge CLK);
      step(1, 32'h100, 0, 1, 0, 0, 0, 0);
      check("t1_idx", idx, 8'h80);
      check("t1_idx_valid", idx_valid, 1);

      // 2: four speculative updates then a request with ASID
      step(0, 0, 0, 1, 1, 1, 0, 0);
      step(0, 0, 0, 1, 1, 1, 0, 0);
      step(0, 0, 0, 1, 1, 1, 0, 0);
      step(0, 0, 0, 1, 1, 0, 0, 0);
      check("t2_ghr", GH_out, 12'h00E);
      step(1, 32'h100, 3, 1, 0, 0, 0, 0);
`ifdef GBPT_HASH_ASID_EN
      check("t2_idx", idx, 8'h8D);
`else
      check("t2_idx", idx, 8'h8E);
`endif
      check("t2_idx_GH", idx_GH, 12'h00E);

      // 3: full-ones history fold
      step(0, 0, 0, 1, 0, 0, 1, 12'hFFF);
      step(1, 0, 0, 1, 0, 0, 0, 0);
      check("t3_idx", idx, 8'hF0);

      // 4: stall holds output, history keeps moving underneath
      step(1, 32'h0000_1234, 5, 1, 0, 0, 0, 0);
      held_idx = idx; held_gh = idx_GH;
      step(1, 32'h0000_0ABC, 2, 0, 1, 1, 0, 0);
      step(1, 32'h0000_0ABC, 2, 0, 0, 0, 0, 0);
      step(1, 32'h0000_0ABC, 2, 0, 1, 0, 0, 0);
      check("t4_held_idx", idx, held_idx);
      check("t4_held_gh",  idx_GH, held_gh);
      check("t4_req_ready_stall", req_ready, 0);
      step(1, 32'h0000_0ABC, 2, 1, 0, 0, 0, 0);
      check("t4_valid_after", idx_valid, 1);
      idle();

      // 5: restore beats same-cycle update
      step(0, 0, 0, 1, 0, 0, 1, 12'h123);
      step(0, 0, 0, 1, 1, 1, 1, 12'h0AA);
      check("t5_ghr", GH_out, 12'h0AA);
      step(1, 0, 0, 1, 0, 0, 0, 0);
      check("t5_idx", idx, 8'hAA);

      // 6: ASID 0xF with GHR=0
      step(0, 0, 0, 1, 0, 0, 1, 0);
      step(1, 32'h100, 4'hF, 1, 0, 0, 0, 0);
`ifdef GBPT_HASH_ASID_EN
      exp_asid_f = 8'h8F;
`else
      exp_asid_f = 8'h80;
`endif
      check("t6_idx", idx, exp_asid_f);

      // reset in the middle of a stall drops the output immediately
      step(1, 32'h40, 1, 1, 1, 1, 0, 0);
      step(1, 32'h80, 1, 0, 0, 0, 0, 0);
      #2 nRST = 0;
      #1;
      check("rst_mid_idx_valid", idx_valid, 0);
      check("rst_mid_GH_out", GH_out, 0);
      model_reset();
      @(negedge CLK);
      nRST = 1;

      // random traffic honouring the hold-while-stalled rule
      p_rv = 0; p_pc = 0; p_asid = 0;
      for (int c = 0; c < 500; c++) begin
         bit rv, ir, uv, ut, rs, pend;
         int unsigned pc, asid, rgh;
         pend = p_rv && !( !m_vld || idx_ready );
         ir   = ($urandom_range(0, 3) != 0);
         uv   = $urandom_range(0, 1);
         ut   = $urandom_range(0, 1);
         rs   = ($urandom_range(0, 9) == 0);
         rgh  = $urandom_range(0, (1 << GHL) - 1);
         if (pend) begin
            rv = 1; pc = p_pc; asid = p_asid;
         end else begin
            rv = $urandom_range(0, 1); pc = $urandom; asid = $urandom_range(0, (1 << AW) - 1);
         end
         p_rv = rv && !(!m_vld || ir); p_pc = pc; p_asid = asid;
         step(rv, pc, asid, ir, uv, ut, rs, rgh);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
